// File: rtl/dift_tcdm_pkg.sv
// Shared types and helpers for the DIFT tagged-TCDM bridges.
// A 36-bit tagged word carries one tag bit above each data byte:
//   {t3, d[31:24], t2, d[23:16], t1, d[15:8], t0, d[7:0]}
// so the tag bits sit at positions 8, 17, 26 and 35.
package dift_tcdm_pkg;

  localparam int TAG_N = 4;
  localparam int TAG_POS [TAG_N] = '{8, 17, 26, 35};

  // One outstanding-transaction record: reads carry the tags to re-merge,
  // writes carry is_read=0 so their response tags come back as zero.
  typedef struct packed {
    logic       is_read;
    logic [3:0] tag;
  } tag_entry_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } word_split_t;

  function automatic logic [35:0] pack36(input logic [31:0] data32,
                                         input logic [3:0]  tag4);
    return {tag4[3], data32[31:24], tag4[2], data32[23:16],
            tag4[1], data32[15:8],  tag4[0], data32[7:0]};
  endfunction

  function automatic word_split_t unpack36(input logic [35:0] data36);
    word_split_t s;
    s.data = {data36[34:27], data36[25:18], data36[16:9], data36[7:0]};
    for (int i = 0; i < TAG_N; i++) begin
      s.tag[i] = data36[TAG_POS[i]];
    end
    return s;
  endfunction

endpackage

// File: rtl/dift_tag_fifo.sv
// Small synchronous FIFO holding per-transaction tag records.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (control only)
//   push, pop    : write / read strobes; push ignored when full, pop when empty
//   full, empty  : derived from the registered occupancy count only
//   wdata, rdata : entry in / head entry out (rdata undefined when empty)
import dift_tcdm_pkg::*;

module dift_tag_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [4:0]
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  input  entry_t wdata,
  output entry_t rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  // No push-through: a full FIFO refuses a push even if it pops this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tcdm_bus_tag_split_36_to_32.sv
// DIFT bridge: 36-bit tagged TCDM initiator -> legacy 32-bit TCDM target.
// Data bytes pass through; the per-byte tag bits live in a local flop array
// indexed by word address and are re-merged into read responses through an
// in-order outstanding-transaction FIFO.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   slave_36_*            : upstream tagged port (req/add/wen/be/wdata36 in,
//                           gnt/r_opc/r_valid/r_data36 out)
//   master_32_*           : downstream plain port (req/add/wen/be/wdata32 out,
//                           gnt/r_opc/r_valid/r_data32 in)
import dift_tcdm_pkg::*;

module tcdm_bus_tag_split_36_to_32 #(
  parameter int          TAG_DEPTH       = 256,
  parameter logic [31:0] ADDR_BASE       = 32'h1C00_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic        DEFAULT_TAG     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slave_36_req,
  input  logic [31:0] slave_36_add,
  input  logic        slave_36_wen,
  input  logic [3:0]  slave_36_be,
  input  logic [35:0] slave_36_wdata,
  output logic        slave_36_gnt,
  output logic        slave_36_r_opc,
  output logic        slave_36_r_valid,
  output logic [35:0] slave_36_r_data,
  output logic        master_32_req,
  output logic [31:0] master_32_add,
  output logic        master_32_wen,
  output logic [3:0]  master_32_be,
  output logic [31:0] master_32_wdata,
  input  logic        master_32_gnt,
  input  logic        master_32_r_opc,
  input  logic        master_32_r_valid,
  input  logic [31:0] master_32_r_data
);

  localparam int          IDX_W        = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [31:0] DEPTH_WORDS  = 32'(TAG_DEPTH);
  localparam logic [3:0]  DEFAULT_TAGS = {4{DEFAULT_TAG}};

  logic             fifo_full;
  logic             fifo_empty;
  logic             hs;
  logic             is_read;
  logic             covered;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [3:0]       tag_mem [TAG_DEPTH];
  logic [3:0]       rsp_tag;
  word_split_t      wsplit;
  tag_entry_t       push_entry;
  tag_entry_t       head_entry;

  // Request path: purely combinational, only throttled by FIFO occupancy.
  assign master_32_req   = slave_36_req & ~fifo_full;
  assign slave_36_gnt    = master_32_gnt & ~fifo_full;
  assign master_32_add   = slave_36_add;
  assign master_32_wen   = slave_36_wen;
  assign master_32_be    = slave_36_be;
  assign wsplit          = unpack36(slave_36_wdata);
  assign master_32_wdata = wsplit.data;

  assign hs      = slave_36_req & slave_36_gnt;
  assign is_read = slave_36_wen;

  // Addresses below the base must not wrap into the array, hence the
  // explicit lower-bound compare alongside the offset range check.
  assign offset  = slave_36_add - ADDR_BASE;
  assign covered = (slave_36_add >= ADDR_BASE) && ((offset >> 2) < DEPTH_WORDS);
  assign idx     = offset[IDX_W+1:2];

  // The array read here is the pre-edge value, so a read never observes a
  // write landing on the same edge.
  always_comb begin
    push_entry = '0;
    if (is_read) begin
      push_entry.is_read = 1'b1;
      push_entry.tag     = covered ? tag_mem[idx] : DEFAULT_TAGS;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem[i] <= DEFAULT_TAGS;
      end
    end else if (hs && !is_read && covered) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_36_be[b]) tag_mem[idx][b] <= wsplit.tag[b];
      end
    end
  end

  dift_tag_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (tag_entry_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs),
    .pop   (master_32_r_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .wdata (push_entry),
    .rdata (head_entry)
  );

  // Response path: an empty FIFO (including during and right after reset)
  // yields default tags rather than stale storage contents.
  always_comb begin
    rsp_tag = DEFAULT_TAGS;
    if (!fifo_empty) rsp_tag = head_entry.is_read ? head_entry.tag : 4'b0000;
  end

  assign slave_36_r_valid = master_32_r_valid;
  assign slave_36_r_opc   = master_32_r_opc;
  assign slave_36_r_data  = pack36(master_32_r_data, rsp_tag);

  a_rvalid_needs_outstanding : assert property (
    @(posedge clk_i) disable iff (rst_i) master_32_r_valid |-> !fifo_empty
  ) else $warning("response with no outstanding request, default tags returned");

endmodule
